// File: rtl/sum_result_fifo.sv
// Show-ahead result FIFO behind the packet summing stage, with sticky overflow.
// Optional per-entry sequence tags when SUM_RESULT_TAG_EN is defined.
module sum_result_fifo #(
    parameter int NOF_BITS = 32,
    parameter int DEPTH    = 4,
    parameter int TAG_BITS = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NOF_BITS:0]   sum_in,
    input  logic                sum_done,
    output logic [NOF_BITS:0]   res_data,
    output logic                res_valid,
    input  logic                res_ready,
`ifdef SUM_RESULT_TAG_EN
    output logic [TAG_BITS-1:0] res_tag,
`endif
    output logic [AW:0]         level,
    output logic                full,
    output logic                overflow,
    input  logic                ovf_clr
);

    logic [NOF_BITS:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic              drop;

    assign res_valid = (level != '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign pop       = res_valid & res_ready;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push      = sum_done & (~full | pop);
    assign drop      = sum_done & full & ~pop;
    assign res_data  = res_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sum_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

`ifdef SUM_RESULT_TAG_EN
    logic [TAG_BITS-1:0] tag_mem [DEPTH];
    logic [TAG_BITS-1:0] tag_cnt;

    // Counter advances on dropped results too, leaving a gap in the tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tag_cnt <= '0;
        else if (sum_done)
            tag_cnt <= tag_cnt + TAG_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= tag_cnt;
    end

    assign res_tag = res_valid ? tag_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_sum_result_fifo.sv
// Scoreboard bench for sum_result_fifo; tag checks active with SUM_RESULT_TAG_EN.
module tb_sum_result_fifo;

    localparam int NB = 32;
    localparam int TB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB:0]   sum_in;
    logic          sum_done;
    logic [NB:0]   res_data;
    logic          res_valid;
    logic          res_ready;
    logic [TB-1:0] res_tag;
    logic [2:0]    level;
    logic          full;
    logic          overflow;
    logic          ovf_clr;

    int n_chk  = 0;
    int n_fail = 0;

    logic [NB:0]   exp_q [$];
    logic [TB-1:0] tag_q [$];

    sum_result_fifo #(.NOF_BITS(NB), .DEPTH(4), .TAG_BITS(TB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sum_in   (sum_in),
        .sum_done (sum_done),
        .res_data (res_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
`ifdef SUM_RESULT_TAG_EN
        .res_tag  (res_tag),
`endif
        .level    (level),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

`ifndef SUM_RESULT_TAG_EN
    assign res_tag = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [NB:0] v, input bit accepted,
                          input logic [TB-1:0] t);
        sum_in   = v;
        sum_done = 1'b1;
        if (accepted) begin
            exp_q.push_back(v);
            tag_q.push_back(t);
        end
    endtask

    // Monitor: every accepted handshake must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h expected none",
                         res_data);
            end else begin
                logic [NB:0]   e;
                logic [TB-1:0] et;
                e  = exp_q.pop_front();
                et = tag_q.pop_front();
                chk("res_data", 64'(res_data), 64'(e));
`ifdef SUM_RESULT_TAG_EN
                chk("res_tag", 64'(res_tag), 64'(et));
`endif
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        sum_in    = '0;
        sum_done  = 1'b0;
        res_ready = 1'b0;
        ovf_clr   = 1'b0;
        #12;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_tag", 64'(res_tag), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // single result passes through with one-cycle latency
        res_ready = 1'b1;
        strobe(33'h1_0000_0005, 1, 8'd0);
        step();
        sum_done = 1'b0;
        chk("single_level1", 64'(level), 64'd1);
        chk("single_valid", 64'(res_valid), 64'd1);
        step();
        chk("single_level0", 64'(level), 64'd0);
        chk("single_valid0", 64'(res_valid), 64'd0);

        // fill, then drop
        res_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            strobe(33'(v), 1, 8'd0);
            step();
        end
        sum_done = 1'b0;
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_ovf0", 64'(overflow), 64'd0);
        strobe(33'd5, 0, 8'd0);
        step();
        sum_done = 1'b0;
        chk("drop_ovf", 64'(overflow), 64'd1);
        chk("drop_level", 64'(level), 64'd4);

        // overflow clear, then clear coinciding with a drop
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'd0);
        ovf_clr = 1'b1;
        strobe(33'd6, 0, 8'd0);
        step();
        ovf_clr  = 1'b0;
        sum_done = 1'b0;
        chk("ovf_set_wins", 64'(overflow), 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr2", 64'(overflow), 64'd0);

        // full with simultaneous pop: 1 leaves, 9 enters
        res_ready = 1'b1;
        strobe(33'd9, 1, 8'd0);
        step();
        sum_done  = 1'b0;
        res_ready = 1'b0;
        chk("fullpop_level", 64'(level), 64'd4);
        chk("fullpop_ovf", 64'(overflow), 64'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_level", 64'(level), 64'd0);

        // sustained streaming
        for (int i = 0; i < 10; i++) begin
            strobe(33'(100 + i), 1, 8'd0);
            step();
            chk("stream_level", 64'(level), 64'd1);
        end
        sum_done = 1'b0;
        step();
        chk("stream_end_level", 64'(level), 64'd0);
        chk("stream_ovf", 64'(overflow), 64'd0);

        // restart so the tag counter begins at 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(33'(11 + i), 1, 8'(i));
            step();
        end
        strobe(33'd15, 0, 8'd4);
        step();
        res_ready = 1'b1;
        strobe(33'd16, 1, 8'd5);
        step();
        sum_done = 1'b0;
        chk("tagseq_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) step();
        chk("tagseq_level", 64'(level), 64'd0);

        // asynchronous reset mid-stream
        res_ready = 1'b0;
        strobe(33'd21, 1, 8'd6);
        step();
        strobe(33'd22, 1, 8'd7);
        step();
        sum_done = 1'b0;
        chk("pre_rst_level", 64'(level), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(res_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_data", 64'(res_data), 64'd0);
        chk("arst_ovf", 64'(overflow), 64'd0);
        chk("arst_tag", 64'(res_tag), 64'd0);
        exp_q.delete();
        tag_q.delete();
        step();
        rst_n = 1'b1;
        step();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
